regfile_scoreboard: RTL

//  Parametrised 2-read/1-write integer register file for the single-cycle RISC-V core, with a per-register

---
 rtl/regfile_scoreboard.sv | 67 ++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with a per-register pending-write scoreboard
//   clock/reset_n       rising-edge clock, asynchronous active-low reset
//   Read1/Read2         read addresses -> Data1/Data2 (combinational), Busy1/Busy2 (pending write)
//   RD/WriteData/RegWrite  write port; a write also retires the pending producer of RD
//   IssueValid/IssueRD  marks IssueRD busy at the clock edge
//   BusyCount           registered number of busy registers
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRD,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   BusyCount
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              run_q, wr, iss, inc, dec;
  // run_q stays low until the first edge after reset release, so a write or issue
  // coincident with deassertion is dropped and nothing is forwarded during reset
  always_comb begin
    wr  = RegWrite && run_q && !(ZERO_REG != 0 && RD == '0);
    iss = IssueValid && run_q && !(ZERO_REG != 0 && IssueRD == '0);
    busy_d = busy_q;
    if (wr) busy_d[RD] = 1'b0;
    if (iss) busy_d[IssueRD] = 1'b1;
    // count tracks the popcount of busy_d incrementally; a retire hidden by a
    // same-register issue leaves the count unchanged
    inc   = iss && !busy_q[IssueRD];
    dec   = wr && busy_q[RD] && !(iss && IssueRD == RD);
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end
  assign Data1 = (ZERO_REG != 0 && Read1 == '0) ? '0 :
                 (BYPASS != 0 && wr && RD == Read1) ? WriteData : rf_q[Read1];
  assign Data2 = (ZERO_REG != 0 && Read2 == '0) ? '0 :
                 (BYPASS != 0 && wr && RD == Read2) ? WriteData : rf_q[Read2];
  assign Busy1 = busy_q[Read1] && !(BYPASS != 0 && wr && RD == Read1 && !(iss && IssueRD == Read1));
  assign Busy2 = busy_q[Read2] && !(BYPASS != 0 && wr && RD == Read2 && !(iss && IssueRD == Read2));
  assign BusyCount = cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      run_q  <= 1'b1;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wr) rf_q[RD] <= WriteData;
    end
  end
endmodule
